// File: rtl/lstm_gate_mac.sv
// Purpose : LSTM gate pre-activation MAC: bias + sum(x*w) over VEC_LEN element pairs, Q9.7 in/out.
// Latency : result valid 1 cycle after the last element is accepted; VEC_LEN+1 cycles per vector minimum.
// Backpressure: in_ready drops while a result is pending; the result is held until out_ready.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     element-pair handshake (in_x, in_w; in_bias taken with first element only)
//   in_x, in_w, in_bias   signed Q9.7 operands
//   out_valid/out_ready   result handshake
//   out_data, out_sat     signed Q9.7 pre-activation and saturation flag, qualified by out_valid
//
// VEC_LEN legal range is 1..256; the 40-bit accumulator cannot wrap in that range
// (256 * 2^30 worst-case products plus the shifted bias stay well inside 2^39).

module lstm_gate_mac #(
    parameter int VEC_LEN = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    input  logic [15:0] in_bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat
);

    // Count must be able to hold VEC_LEN itself (e.g. 9 bits for 256).
    localparam int               CNT_W    = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic signed [39:0] acc;
    logic signed [39:0] acc_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic signed [31:0] product;
    logic signed [39:0] prod_ext;
    logic signed [39:0] bias_ext;
    logic signed [39:0] acc_shr;

    logic [15:0]        sat_data;
    logic               sat_flag;
    logic               load_out;

    // ------------------------------------------------------------------
    // Datapath operands
    // ------------------------------------------------------------------

    // Q9.7 * Q9.7 -> Q18.14, full precision; operands are widened first so
    // the multiply is evaluated at 32 bits.
    assign product  = 32'($signed(in_x)) * 32'($signed(in_w));
    assign prod_ext = {{8{product[31]}}, product};

    // Bias is Q9.7; shifting left by 7 aligns it to the accumulator's Q.14.
    assign bias_ext = {{17{in_bias[15]}}, in_bias, 7'd0};

    // ------------------------------------------------------------------
    // Output conversion: Q.14 -> Q9.7 by arithmetic right shift (floor),
    // then clamp into the signed 16-bit range. Computed from acc_nxt so the
    // value can be registered on the same edge as the last accept.
    // ------------------------------------------------------------------

    assign acc_shr = acc_nxt >>> 7;

    always_comb begin
        sat_data = acc_shr[15:0];
        sat_flag = 1'b0;
        if (acc_shr > 40'sd32767) begin
            sat_data = 16'h7FFF;
            sat_flag = 1'b1;
        end else if (acc_shr < -40'sd32768) begin
            sat_data = 16'h8000;
            sat_flag = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state, handshake outputs and accumulator update
    // ------------------------------------------------------------------

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_out  = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // First element of a vector: start from the bias.
                    acc_nxt   = bias_ext + prod_ext;
                    count_nxt = CNT_W'(1);
                    if (VEC_LEN == 1) begin
                        state_nxt = OUTPUT;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end

            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt   = acc + prod_ext;
                    count_nxt = count + 1'b1;
                    if (count_nxt == CNT_LAST) begin
                        state_nxt = OUTPUT;
                        load_out  = 1'b1;
                    end
                end
            end

            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. out_data/out_sat only change when a new result is
    // produced (or on reset), so they stay stable through any stall.
    // ------------------------------------------------------------------

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            if (load_out) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Purpose : self-checking bench for lstm_gate_mac (VEC_LEN=4), directed corner vectors plus random vectors.
// Latency : checks out_valid one cycle after the last accept and VEC_LEN+1 cycle vector spacing.
// Backpressure: exercises input bubbles and out_ready stalls, checking hold/stability of the result.

module tb_lstm_gate_mac;

    localparam int VL = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic [15:0] in_bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int n_vec;
    int n_err;
    int cyc;

    // Current vector under test.
    logic [15:0] vbias;
    logic [15:0] vx [VL];
    logic [15:0] vw [VL];

    lstm_gate_mac #(.VEC_LEN(VL)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: exact integer arithmetic on real-valued fixed point.
    // sum = bias*2^7 + sum(x*w) in units of 2^-14; result = floor(sum / 2^7), clamped.
    function automatic logic [16:0] model();
        longint s;
        longint r;
        s = longint'($signed(vbias)) * 128;
        for (int i = 0; i < VL; i++)
            s += longint'($signed(vx[i])) * longint'($signed(vw[i]));
        r = s >>> 7;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, r[15:0]};
    endfunction

    task automatic fill_const(input logic [15:0] b, input logic [15:0] x, input logic [15:0] w);
        vbias = b;
        for (int i = 0; i < VL; i++) begin
            vx[i] = x;
            vw[i] = w;
        end
    endtask

    // Drives the current vector with `gap` idle cycles before each element,
    // holds out_ready low for `stall` cycles once the result is up, and checks
    // handshake timing, result value and hold behaviour against the model.
    task automatic run_vector(input string name, input int gap, input int stall,
                              output logic [15:0] got_d, output logic got_s,
                              output int rise_cyc);
        logic [16:0] exp;
        exp = model();
        out_ready = (stall == 0);
        for (int i = 0; i < VL; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_x     = 16'($urandom);
                in_w     = 16'($urandom);
                in_bias  = 16'($urandom);
                @(negedge clock);
            end
            in_valid = 1'b1;
            in_x     = vx[i];
            in_w     = vw[i];
            // Bias on later elements must be ignored.
            in_bias  = (i == 0) ? vbias : 16'($urandom);
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s elem%0d handshake: in_ready=%b out_valid=%b, required 1/0",
                         name, i, in_ready, out_valid);
            end
            @(negedge clock);
        end
        // Junk offered while the result is pending must not be consumed.
        in_valid = 1'b1;
        in_x     = 16'($urandom);
        in_w     = 16'($urandom);
        in_bias  = 16'($urandom);
        rise_cyc = cyc;
        got_d    = out_data;
        got_s    = out_sat;
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s latency: out_valid=%b in_ready=%b, required 1/0", name, out_valid, in_ready);
        end
        n_vec++;
        if (out_data !== exp[15:0] || out_sat !== exp[16]) begin
            n_err++;
            $display("FAIL %s result: got data=%h sat=%b, required data=%h sat=%b",
                     name, out_data, out_sat, exp[15:0], exp[16]);
        end
        for (int s = 1; s < stall; s++) begin
            @(negedge clock);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== got_d || out_sat !== got_s) begin
                n_err++;
                $display("FAIL %s stall%0d hold: out_valid=%b in_ready=%b data=%h sat=%b, required 1/0/%h/%b",
                         name, s, out_valid, in_ready, out_data, out_sat, got_d, got_s);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic expect_const(input string name, input logic [15:0] d, input logic s,
                                input logic [15:0] exp_d, input logic exp_s);
        n_vec++;
        if (d !== exp_d || s !== exp_s) begin
            n_err++;
            $display("FAIL %s constant: got data=%h sat=%b, required data=%h sat=%b",
                     name, d, s, exp_d, exp_s);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_x      = 16'h1234;
        in_w      = 16'h0100;
        in_bias   = 16'h0400;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b data=%h sat=%b, required 1/0/0000/0",
                     in_ready, out_valid, out_data, out_sat);
        end
    endtask

    task automatic test_directed();
        logic [15:0] d;
        logic        s;
        int          r;
        fill_const(16'h0000, 16'h0080, 16'h0040);
        run_vector("basic", 0, 0, d, s, r);
        expect_const("basic", d, s, 16'h0100, 1'b0);
        fill_const(16'h0080, 16'hFF80, 16'h0001);
        run_vector("neg_floor", 0, 0, d, s, r);
        expect_const("neg_floor", d, s, 16'h007C, 1'b0);
        fill_const(16'h0000, 16'h0001, 16'h0001);
        run_vector("trunc_pos", 0, 0, d, s, r);
        expect_const("trunc_pos", d, s, 16'h0000, 1'b0);
        fill_const(16'h0000, 16'hFFFF, 16'h0001);
        run_vector("trunc_neg", 0, 0, d, s, r);
        expect_const("trunc_neg", d, s, 16'hFFFF, 1'b0);
        fill_const(16'h0000, 16'h7FFF, 16'h7FFF);
        run_vector("sat_pos", 0, 0, d, s, r);
        expect_const("sat_pos", d, s, 16'h7FFF, 1'b1);
        fill_const(16'h0000, 16'h8000, 16'h7FFF);
        run_vector("sat_neg", 0, 0, d, s, r);
        expect_const("sat_neg", d, s, 16'h8000, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic        s;
        int          r;
        fill_const(16'h0000, 16'h0080, 16'h0040);
        run_vector("bubbles_stall", 2, 5, d, s, r);
        expect_const("bubbles_stall", d, s, 16'h0100, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic        s;
        int          r0;
        int          r1;
        fill_const(16'h0040, 16'h0100, 16'hFF00);
        run_vector("b2b_a", 0, 0, d, s, r0);
        fill_const(16'hFFC0, 16'h0020, 16'h0300);
        run_vector("b2b_b", 0, 0, d, s, r1);
        n_vec++;
        if (r1 - r0 !== VL + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d", r1 - r0, VL + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        s;
        int          r;
        // Partial vector with a large bias, then reset.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = 16'h0400;
            in_w     = 16'h0400;
            in_bias  = 16'h2000;
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_vector: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        fill_const(16'h0000, 16'h0080, 16'h0040);
        run_vector("after_reset", 0, 0, d, s, r);
        expect_const("after_reset", d, s, 16'h0100, 1'b0);

        // Reset while a result is pending must drop it and clear the outputs.
        fill_const(16'h0100, 16'h0100, 16'h0100);
        out_ready = 1'b0;
        for (int i = 0; i < VL; i++) begin
            in_valid = 1'b1;
            in_x     = vx[i];
            in_w     = vw[i];
            in_bias  = vbias;
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_output: out_valid=%b in_ready=%b data=%h sat=%b, required 0/1/0000/0",
                     out_valid, in_ready, out_data, out_sat);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        s;
        int          r;
        for (int n = 0; n < 40; n++) begin
            vbias = 16'($urandom);
            for (int i = 0; i < VL; i++) begin
                // Mix small operands (no clamp) with full-range ones (likely clamp).
                if (n % 2 == 0) begin
                    vx[i] = 16'($signed(10'($urandom)));
                    vw[i] = 16'($signed(10'($urandom)));
                end else begin
                    vx[i] = 16'($urandom);
                    vw[i] = 16'($urandom);
                end
            end
            run_vector("random", $urandom_range(0, 2), $urandom_range(0, 3), d, s, r);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_bias   = '0;
        out_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
